// File: rtl/zero_detect_arbiter.sv
// zero_detect_arbiter: shares one WIDTH-input NOR zero-detector between the
// ID-stage branch comparator (port A) and the EX-stage ALU zero path (port B).
// Port A has priority. A saturating wait counter forces port B through after
// MAX_WAIT consecutive cycles without a grant. The detector result is
// captured with the requester ID in a one-entry, stallable response buffer.
module zero_detect_arbiter #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MAX_WAIT = 3
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req_a_valid,
  input  logic [WIDTH-1:0] req_a_data,
  output logic             req_a_ready,
  input  logic             req_b_valid,
  input  logic [WIDTH-1:0] req_b_data,
  output logic             req_b_ready,
  output logic [WIDTH-1:0] nor_operand,
  input  logic             zero_in,
  input  logic             flush,
  output logic             rsp_valid,
  output logic             rsp_zero,
  output logic             rsp_id,
  input  logic             rsp_ready
);

  localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

  logic       rsp_valid_q, rsp_valid_d;
  logic       rsp_zero_q,  rsp_zero_d;
  logic       rsp_id_q,    rsp_id_d;
  logic [3:0] wait_b_q,    wait_b_d;

  logic can_issue_s;
  logic force_b_s;
  logic grant_a_s;
  logic grant_b_s;

  // Grant decision: B wins when forced by starvation or when A is idle.
  // Grants are suppressed while reset is asserted so the readies read 0.
  always_comb begin
    can_issue_s = !flush && (!rsp_valid_q || rsp_ready);
    force_b_s   = req_b_valid && (wait_b_q == MaxWait);
    grant_a_s   = 1'b0;
    grant_b_s   = 1'b0;
    if (reset_n && can_issue_s) begin
      grant_b_s = req_b_valid && (force_b_s || !req_a_valid);
      grant_a_s = req_a_valid && !grant_b_s;
    end else begin
      grant_a_s = 1'b0;
      grant_b_s = 1'b0;
    end
  end

  // Detector operand mux: granted requester's data, all-zero otherwise.
  always_comb begin
    nor_operand = {WIDTH{1'b0}};
    case ({grant_b_s, grant_a_s})
      2'b10:   nor_operand = req_b_data;
      2'b01:   nor_operand = req_a_data;
      default: nor_operand = {WIDTH{1'b0}};
    endcase
  end

  // Response buffer next state: flush beats load, load beats consume.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_zero_d  = rsp_zero_q;
    rsp_id_d    = rsp_id_q;
    if (flush) begin
      rsp_valid_d = 1'b0;
    end else if (grant_a_s || grant_b_s) begin
      rsp_valid_d = 1'b1;
      rsp_zero_d  = zero_in;
      rsp_id_d    = grant_b_s;
    end else if (rsp_ready && rsp_valid_q) begin
      rsp_valid_d = 1'b0;
    end else begin
      rsp_valid_d = rsp_valid_q;
    end
  end

  // Starvation counter for B: counts ungranted cycles, including stalls.
  always_comb begin
    wait_b_d = wait_b_q;
    if (flush || grant_b_s || !req_b_valid) begin
      wait_b_d = 4'd0;
    end else if (wait_b_q < MaxWait) begin
      wait_b_d = wait_b_q + 4'd1;
    end else begin
      wait_b_d = MaxWait;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid_q <= 1'b0;
      rsp_zero_q  <= 1'b0;
      rsp_id_q    <= 1'b0;
      wait_b_q    <= 4'd0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_zero_q  <= rsp_zero_d;
      rsp_id_q    <= rsp_id_d;
      wait_b_q    <= wait_b_d;
    end
  end

  assign req_a_ready = grant_a_s;
  assign req_b_ready = grant_b_s;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_zero    = rsp_zero_q;
  assign rsp_id      = rsp_id_q;

endmodule

// File: tb/tb_zero_detect_arbiter.sv
// Bench for zero_detect_arbiter: directed scenarios with literal expectations
// followed by randomized traffic checked every cycle against a behavioural model.
module tb_zero_detect_arbiter;

  localparam int W  = 32;
  localparam int MW = 3;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          req_a_valid = 1'b0;
  logic [W-1:0]  req_a_data = 32'h0;
  logic          req_a_ready;
  logic          req_b_valid = 1'b0;
  logic [W-1:0]  req_b_data = 32'h0;
  logic          req_b_ready;
  logic [W-1:0]  nor_operand;
  logic          zero_in;
  logic          flush = 1'b0;
  logic          rsp_valid;
  logic          rsp_zero;
  logic          rsp_id;
  logic          rsp_ready = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  // Shared detector: a plain NOR over the operand.
  assign zero_in = (nor_operand == 32'h0);

  always #5 clock = ~clock;

  zero_detect_arbiter #(.WIDTH(W), .MAX_WAIT(MW)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_a_valid (req_a_valid),
    .req_a_data  (req_a_data),
    .req_a_ready (req_a_ready),
    .req_b_valid (req_b_valid),
    .req_b_data  (req_b_data),
    .req_b_ready (req_b_ready),
    .nor_operand (nor_operand),
    .zero_in     (zero_in),
    .flush       (flush),
    .rsp_valid   (rsp_valid),
    .rsp_zero    (rsp_zero),
    .rsp_id      (rsp_id),
    .rsp_ready   (rsp_ready)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic av, input logic [W-1:0] ad, input logic bv,
                       input logic [W-1:0] bd, input logic fl, input logic rr);
    req_a_valid = av; req_a_data = ad;
    req_b_valid = bv; req_b_data = bd;
    flush = fl; rsp_ready = rr;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // Behavioural model: who may be served this cycle, what the buffer holds,
  // and how many cycles B has been left waiting. Checked at every falling edge.
  bit m_valid = 0;
  bit m_zero  = 0;
  bit m_id    = 0;
  int m_wait  = 0;

  initial forever begin
    bit eligible, gb, ga;
    logic [W-1:0] exp_op;
    @(negedge clock);
    if (!reset_n) begin
      m_valid = 0; m_zero = 0; m_id = 0; m_wait = 0;
      chk("m_rst_a_ready", req_a_ready, 0);
      chk("m_rst_b_ready", req_b_ready, 0);
      chk("m_rst_operand", nor_operand, 0);
      chk("m_rst_valid",   rsp_valid,   0);
    end else begin
      eligible = !flush && (!m_valid || rsp_ready);
      gb = eligible && req_b_valid && (m_wait >= MW || !req_a_valid);
      ga = eligible && req_a_valid && !gb;
      exp_op = gb ? req_b_data : (ga ? req_a_data : 32'h0);
      chk("m_a_ready",   req_a_ready, ga);
      chk("m_b_ready",   req_b_ready, gb);
      chk("m_operand",   nor_operand, exp_op);
      chk("m_rsp_valid", rsp_valid,   m_valid);
      chk("m_rsp_zero",  rsp_zero,    m_zero);
      chk("m_rsp_id",    rsp_id,      m_id);
      if (flush)            m_valid = 0;
      else if (ga || gb) begin
        m_valid = 1;
        m_zero  = gb ? (req_b_data == 0) : (req_a_data == 0);
        m_id    = gb;
      end else if (rsp_ready && m_valid) m_valid = 0;
      if (flush || gb || !req_b_valid) m_wait = 0;
      else m_wait = (m_wait + 1 > MW) ? MW : m_wait + 1;
    end
  end

  initial begin
    bit pat [8];
    int r;
    pat = '{0, 0, 0, 1, 0, 0, 0, 1};

    // Reset state
    #2;
    chk("reset_valid",   rsp_valid,   0);
    chk("reset_zero",    rsp_zero,    0);
    chk("reset_id",      rsp_id,      0);
    chk("reset_a_ready", req_a_ready, 0);
    next_cycle();
    next_cycle();
    reset_n = 1'b1;

    // A only, zero operand
    drive(1, 32'h0, 0, 32'h0, 0, 1);
    #1;
    chk("a0_ready", req_a_ready, 1);
    next_cycle();
    chk("a0_rsp_valid", rsp_valid, 1);
    chk("a0_rsp_zero",  rsp_zero,  1);
    chk("a0_rsp_id",    rsp_id,    0);

    // Continuous A and B: B forced every fourth grant
    drive(0, 32'h0, 0, 32'h0, 0, 1);
    next_cycle();
    drive(1, 32'h1, 1, 32'h0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("rr_b_ready", req_b_ready, pat[i]);
      chk("rr_a_ready", req_a_ready, !pat[i]);
      if (i > 0) begin
        chk("rr_rsp_id",   rsp_id,   pat[i-1]);
        chk("rr_rsp_zero", rsp_zero, pat[i-1]);
      end
      next_cycle();
    end
    chk("rr_last_id",   rsp_id,   1);
    chk("rr_last_zero", rsp_zero, 1);

    // Backpressure
    drive(0, 32'h0, 0, 32'h0, 0, 1);
    next_cycle();
    drive(1, 32'h8000_0000, 0, 32'h0, 0, 0);
    #1;
    chk("bp_grant", req_a_ready, 1);
    next_cycle();
    drive(1, 32'h1, 0, 32'h0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_a_ready", req_a_ready, 0);
      chk("bp_b_ready", req_b_ready, 0);
      chk("bp_valid",   rsp_valid,   1);
      chk("bp_zero",    rsp_zero,    0);
      chk("bp_id",      rsp_id,      0);
      next_cycle();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_grant", req_a_ready, 1);
    next_cycle();
    chk("bp_release_valid", rsp_valid, 1);

    // Flush blocks B, then B goes through
    drive(0, 32'h0, 1, 32'h0, 1, 1);
    #1;
    chk("fl_b_ready", req_b_ready, 0);
    next_cycle();
    chk("fl_valid", rsp_valid, 0);
    flush = 1'b0;
    #1;
    chk("fl_retry_b_ready", req_b_ready, 1);
    next_cycle();
    chk("fl_retry_zero", rsp_zero, 1);
    chk("fl_retry_id",   rsp_id,   1);

    // Reset mid-transaction
    drive(1, 32'h5, 0, 32'h0, 0, 0);
    next_cycle();
    chk("mid_valid_before", rsp_valid, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid",   rsp_valid,   0);
    chk("mid_rst_a_ready", req_a_ready, 0);
    chk("mid_rst_operand", nor_operand, 0);
    next_cycle();
    reset_n = 1'b1;
    #1;
    chk("mid_after_a_ready", req_a_ready, 1);
    next_cycle();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 3);
      drive($urandom_range(0, 2) != 0, (r == 0) ? 32'h0 : $urandom,
            $urandom_range(0, 1) == 1, ($urandom_range(0, 2) == 0) ? 32'h0 : $urandom,
            $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0);
      next_cycle();
    end

    drive(0, 32'h0, 0, 32'h0, 0, 1);
    next_cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
